// File: rtl/lab_readout_seq.sv
// Readout sequencer for four LAB digitizers: hold, digitize, wait for done, then
// stream each selected LAB's RAM through a small FIFO to a valid/ready consumer.
module lab_readout_seq #(
   parameter int NWORDS  = 1536,
   parameter int TIMEOUT = 1048576
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        trig_i,
   input  logic [3:0]  mask_i,
   output logic [3:0]  hold_o,
   output logic [3:0]  digitize_o,
   output logic [12:0] addr_o,
   input  logic        done_i,
   input  logic [31:0] dat_i,
   output logic [31:0] m_dat_o,
   output logic [1:0]  m_lab_o,
   output logic        m_last_o,
   output logic        m_valid_o,
   input  logic        m_ready_i,
   output logic        busy_o,
   output logic        err_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [10:0] LAST_IDX = 11'(NWORDS - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_HOLD, S_DIGI, S_SETTLE, S_WAIT, S_READ, S_DRAIN, S_NEXT, S_REL
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    mask_q, mask_d;
   logic [3:0]    hold_mask_q, hold_mask_d;
   logic [1:0]    lab_q, lab_d;
   logic [10:0]   idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          settle_q, settle_d;
   logic          err_q, err_d;
   logic          rd_vld_q, rd_vld_d;
   logic          rd_last_q, rd_last_d;
   logic [1:0]    wr_ptr_q, wr_ptr_d;
   logic [1:0]    rd_ptr_q, rd_ptr_d;
   logic [2:0]    count_q, count_d;

   logic [31:0]   fifo_dat_q  [4];
   logic [1:0]    fifo_lab_q  [4];
   logic          fifo_last_q [4];

   logic          push, pop, issue;
   logic [2:0]    occ;
   logic [3:0]    rem;

   function automatic logic [1:0] lowest_lab(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Reads in flight count against FIFO space so a stalled consumer never overflows it.
   assign push  = rd_vld_q;
   assign pop   = m_valid_o & m_ready_i;
   assign occ   = count_q + {2'b00, rd_vld_q};
   assign issue = (state_q == S_READ) && (occ <= 3'd2);

   // NOTE: every _d takes its default before the case, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      hold_mask_d = hold_mask_q;
      lab_d       = lab_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      settle_d    = settle_q;
      err_d       = err_q;
      rd_vld_d    = issue;
      rd_last_d   = issue && (idx_q == LAST_IDX);
      wr_ptr_d    = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
      rem         = mask_q & ~(4'b0001 << lab_q);
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (trig_i && (mask_i != 4'd0)) begin
               mask_d      = mask_i;
               hold_mask_d = mask_i;
               err_d       = 1'b0;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: state_d = S_DIGI;
         S_DIGI: begin
            settle_d = 1'b0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q) begin
               lab_d   = lowest_lab(mask_q);
               idx_d   = 11'd0;
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               settle_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (done_i) begin
               state_d = S_READ;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READ: begin
            if (issue) begin
               if (idx_q == LAST_IDX) state_d = S_DRAIN;
               else                   idx_d   = idx_q + 11'd1;
            end
         end
         S_DRAIN: begin
            if ((count_q == 3'd0) && !rd_vld_q) state_d = S_NEXT;
         end
         S_NEXT: begin
            mask_d = rem;
            idx_d  = 11'd0;
            cnt_d  = '0;
            if (rem != 4'd0) begin
               lab_d   = lowest_lab(rem);
               state_d = S_WAIT;
            end else begin
               state_d = S_REL;
            end
         end
         S_REL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: registers take <= so every flop updates from values sampled before the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         mask_q      <= 4'd0;
         hold_mask_q <= 4'd0;
         lab_q       <= 2'd0;
         idx_q       <= 11'd0;
         cnt_q       <= '0;
         settle_q    <= 1'b0;
         err_q       <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_last_q   <= 1'b0;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         count_q     <= 3'd0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         hold_mask_q <= hold_mask_d;
         lab_q       <= lab_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         settle_q    <= settle_d;
         err_q       <= err_d;
         rd_vld_q    <= rd_vld_d;
         rd_last_q   <= rd_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // NOTE: FIFO storage has no reset; only occupancy does, and outputs are gated by valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_dat_q[wr_ptr_q]  <= dat_i;
         fifo_lab_q[wr_ptr_q]  <= lab_q;
         fifo_last_q[wr_ptr_q] <= rd_last_q;
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign hold_o     = ((state_q != S_IDLE) && (state_q != S_REL)) ? hold_mask_q : 4'd0;
   assign digitize_o = (state_q == S_DIGI) ? hold_mask_q : 4'd0;
   assign addr_o     = ((state_q == S_WAIT) || (state_q == S_READ) || (state_q == S_DRAIN))
                       ? {lab_q, idx_q} : 13'd0;
   assign err_o      = err_q;
   assign m_valid_o  = (count_q != 3'd0);
   assign m_dat_o    = m_valid_o ? fifo_dat_q[rd_ptr_q]  : 32'd0;
   assign m_lab_o    = m_valid_o ? fifo_lab_q[rd_ptr_q]  : 2'd0;
   assign m_last_o   = m_valid_o ? fifo_last_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_lab_readout_seq.sv
// Randomized bench for lab_readout_seq: LAB RAM/done model, expected-word queue
// filled at trigger time, and a negedge monitor that pops and compares transfers.
module tb_lab_readout_seq;

   localparam int NWORDS  = 1536;
   localparam int TIMEOUT = 64;

   typedef struct packed {
      logic [1:0]  lab;
      logic        last;
      logic [31:0] dat;
   } word_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        trig_i = 1'b0;
   logic [3:0]  mask_i = 4'd0;
   logic [3:0]  hold_o, digitize_o;
   logic [12:0] addr_o;
   logic        done_i;
   logic [31:0] dat_i = 32'd0;
   logic [31:0] m_dat_o;
   logic [1:0]  m_lab_o;
   logic        m_last_o, m_valid_o;
   logic        m_ready_i = 1'b1;
   logic        busy_o, err_o;

   lab_readout_seq #(.NWORDS(NWORDS), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i), .mask_i(mask_i),
      .hold_o(hold_o), .digitize_o(digitize_o), .addr_o(addr_o), .done_i(done_i),
      .dat_i(dat_i), .m_dat_o(m_dat_o), .m_lab_o(m_lab_o), .m_last_o(m_last_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] salt = 32'h1234_5678;
   bit          rnd_ready = 1'b0;
   bit          exp_err = 1'b0;
   word_t       exp_q[$];

   int          dly[4];
   int          dcnt[4] = '{0, 0, 0, 0};
   logic [3:0]  lab_done = 4'd0;

   int          run_xfers, digi_cnt, digi_cyc, err_cyc, rel_cnt, busy_cnt, hold_cnt;
   logic [3:0]  hold_seen, digi_seen;
   int          lab_first[4], lab_last[4], lab_cnt[4];
   bit          stall_prev = 1'b0;
   word_t       stall_word, mon_cur, mon_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ram_word(input logic [12:0] a);
      return salt ^ {a[12:11], 30'd0} ^ (32'(a[10:0]) * 32'h9E37_79B1);
   endfunction

   always @(posedge clk_i) cyc <= cyc + 1;
   always @(posedge clk_i) dat_i <= ram_word(addr_o);

   // Each LAB raises done a programmed number of cycles after its digitize pulse; 0 = never.
   always @(posedge clk_i) begin
      for (int n = 0; n < 4; n++) begin
         if (digitize_o[n]) begin
            dcnt[n]     <= dly[n];
            lab_done[n] <= 1'b0;
         end else if (dcnt[n] == 1) begin
            lab_done[n] <= 1'b1;
            dcnt[n]     <= 0;
         end else if (dcnt[n] > 1) begin
            dcnt[n] <= dcnt[n] - 1;
         end
      end
   end
   assign done_i = lab_done[addr_o[12:11]];

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         m_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            stall_prev = 1'b0;
         end else begin
            mon_cur = {m_lab_o, m_last_o, m_dat_o};
            if (stall_prev) check("stall_stable", {m_valid_o, mon_cur}, {1'b1, stall_word});
            if (digitize_o != 4'd0) begin
               digi_cnt++;
               digi_cyc  = cyc;
               digi_seen = digitize_o;
               hold_seen = hold_o;
            end
            if (busy_o && hold_o == 4'd0) rel_cnt++;
            if (busy_o) busy_cnt++;
            if (hold_o != 4'd0) hold_cnt++;
            if (err_o && err_cyc < 0) err_cyc = cyc;
            if (m_valid_o && m_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL spurious_word: got %0h, expected no word", mon_cur);
               end else begin
                  mon_exp = exp_q.pop_front();
                  check("word", mon_cur, mon_exp);
               end
               run_xfers++;
               if (lab_cnt[m_lab_o] == 0) lab_first[m_lab_o] = cyc;
               lab_last[m_lab_o] = cyc;
               lab_cnt[m_lab_o]++;
            end
            stall_prev = m_valid_o && !m_ready_i;
            stall_word = mon_cur;
         end
      end
   end

   task automatic clear_stats();
      run_xfers = 0; digi_cnt = 0; rel_cnt = 0; busy_cnt = 0; hold_cnt = 0;
      err_cyc = -1; digi_cyc = 0; hold_seen = 4'd0; digi_seen = 4'd0;
      for (int n = 0; n < 4; n++) begin
         lab_cnt[n] = 0; lab_first[n] = 0; lab_last[n] = 0;
      end
   endtask

   // Starts at posedge+1; returns at posedge+1 after the trigger edge.
   task automatic launch(input logic [3:0] mask, input int d0, input int d1,
                         input int d2, input int d3, input bit rnd);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
      rnd_ready = rnd;
      salt = $urandom;
      clear_stats();
      exp_err = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (mask[n]) begin
            if (dly[n] == 0) exp_err = 1'b1;
            else for (int i = 0; i < NWORDS; i++)
               exp_q.push_back({2'(n), i == NWORDS - 1, ram_word({2'(n), 11'(i)})});
         end
      end
      trig_i = 1'b1;
      mask_i = mask;
      @(posedge clk_i);
      #1;
      trig_i = 1'b0;
      mask_i = 4'($urandom);
      check("busy_after_trig", busy_o, 1);
      check("err_cleared_by_trig", err_o, 0);
   endtask

   task automatic finish_run(input logic [3:0] mask, input bit retrig, input bit rate_chk);
      bit pulsed = 1'b0;
      int lo = 0;
      for (int c = 0; c < 20000 && busy_o; c++) begin
         if (retrig && !pulsed && run_xfers >= 100) begin
            trig_i = 1'b1;
            mask_i = 4'hF;
            pulsed = 1'b1;
         end else begin
            trig_i = 1'b0;
         end
         @(posedge clk_i);
         #1;
      end
      trig_i = 1'b0;
      check("run_ends_idle", busy_o, 0);
      check("words_left", exp_q.size(), 0);
      exp_q.delete();
      check("digitize_pulses", digi_cnt, 1);
      check("digitize_mask", digi_seen, mask);
      check("hold_mask", hold_seen, mask);
      check("rel_cycles", rel_cnt, 1);
      check("err_flag", err_o, exp_err);
      if (exp_err) check("timeout_cycle", err_cyc - digi_cyc, TIMEOUT + 3);
      if (rate_chk) begin
         for (int n = 0; n < 4; n++)
            if (mask[n] && dly[n] != 0) check("burst_rate", lab_last[n] - lab_first[n], NWORDS - 1);
         while (!mask[lo]) lo++;
         if (dly[lo] != 0)
            check("first_word_latency", (lab_first[lo] - digi_cyc) <= dly[lo] + 5, 1);
      end
   endtask

   initial begin
      clear_stats();
      dly = '{10, 10, 10, 10};
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_outputs", {hold_o, digitize_o, addr_o, m_valid_o, m_last_o, busy_o, err_o,
                              m_dat_o, m_lab_o}, 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Trigger with empty mask is ignored.
      clear_stats();
      trig_i = 1'b1;
      mask_i = 4'd0;
      @(posedge clk_i);
      #1;
      trig_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      check("empty_mask_busy", busy_cnt, 0);
      check("empty_mask_hold", hold_cnt, 0);
      check("empty_mask_digitize", digi_cnt, 0);

      // LAB0 then LAB2 at full rate.
      launch(4'b0101, 10, 10, 10, 10, 1'b0);
      finish_run(4'b0101, 1'b0, 1'b1);

      // Single LAB with a random consumer.
      launch(4'b0001, 10, 10, 10, 10, 1'b1);
      finish_run(4'b0001, 1'b0, 1'b0);

      // LAB0 never finishes: timeout, then LAB1 streams.
      launch(4'b0011, 0, 10, 10, 10, 1'b0);
      finish_run(4'b0011, 1'b0, 1'b1);

      // Retrigger during READ is ignored.
      launch(4'b0001, 7, 10, 10, 10, 1'b1);
      finish_run(4'b0001, 1'b1, 1'b0);

      // Reset at word 700 of LAB1, then a clean run.
      launch(4'b0011, 10, 10, 10, 10, 1'b0);
      for (int c = 0; c < 10000 && lab_cnt[1] < 700; c++) begin
         @(posedge clk_i);
         #1;
      end
      check("reached_lab1_word700", lab_cnt[1], 700);
      rst_i = 1'b1;
      exp_q.delete();
      @(posedge clk_i);
      #1;
      check("midread_reset_outputs", {hold_o, digitize_o, addr_o, m_valid_o, m_last_o, busy_o,
                                      err_o, m_dat_o, m_lab_o}, 64'd0);
      rst_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("no_word_after_reset", {m_valid_o, busy_o}, 2'b00);
      launch(4'b0011, 12, 5, 10, 10, 1'b1);
      finish_run(4'b0011, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lab_readout_seq.md
LAB_READOUT_SEQ -- requirements
Module: lab_readout_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 1536, meaning 32-bit words read per LAB (addresses 0..NWORDS-1).
REQ-002 SHALL have parameter TIMEOUT, default 1048576, meaning clk_i cycles allowed for one LAB's done before abandoning it.
REQ-003 SHALL have port clk_i  in  1  sole clock; every register samples on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port trig_i  in  1  start request, sampled only in IDLE.
REQ-006 SHALL have port mask_i  in  4  LABs to process, bit n = LAB n; latched on accepted trigger.
REQ-007 SHALL have port hold_o  out  4  per-LAB hold, drives LAB top hold_i.
REQ-008 SHALL have port digitize_o  out  4  per-LAB single-cycle digitize pulse, drives LAB top digitize_i.
REQ-009 SHALL have port addr_o  out  13  LAB RAM address; [12:11] LAB select, [10:0] word index.
REQ-010 SHALL have port done_i  in  1  done flag of the LAB selected by addr_o[12:11].
REQ-011 SHALL have port dat_i  in  32  RAM data, valid exactly 1 cycle after addr_o.
REQ-012 SHALL have port m_dat_o  out  32  output word.
REQ-013 SHALL have port m_lab_o  out  2  LAB number of the m_dat_o word.
REQ-014 SHALL have port m_last_o  out  1  high on word NWORDS-1 of a LAB.
REQ-015 SHALL have port m_valid_o  out  1  output word valid.
REQ-016 SHALL have port m_ready_i  in  1  consumer accept; transfer when m_valid_o and m_ready_i both high at a clock edge.
REQ-017 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-018 SHALL have port err_o  out  1  sticky timeout flag; cleared by rst_i or by the next accepted trigger.

Function
REQ-019 SHALL implement states IDLE, HOLD, DIGI, SETTLE, WAIT, READ, DRAIN, NEXT, REL.
REQ-020 IDLE: trig_i=1 with mask_i!=0 -> latch mask, HOLD; trig_i with mask_i=0 ignored; trig_i outside IDLE ignored, no queueing.
REQ-021 HOLD: hold_o = latched mask for one cycle, then DIGI; hold_o stays asserted through REL.
REQ-022 DIGI: digitize_o = latched mask for exactly one cycle, then SETTLE.
REQ-023 SETTLE: 2 cycles, so stale done flags clear, then WAIT on the lowest-numbered remaining LAB.
REQ-024 WAIT: addr_o = {lab,11'd0}; done_i=1 -> READ; per-LAB cycle counter reaches TIMEOUT -> set err_o, drop that LAB with no words emitted, go NEXT.
REQ-025 READ: issue addresses 0..NWORDS-1 in order, at most one per cycle; each issued word enters a 4-entry output FIFO one cycle later.
REQ-026 Issue rule: issue only when FIFO occupancy plus in-flight reads <= 2; no word dropped, duplicated or reordered under any m_ready_i pattern.
REQ-027 With m_ready_i held high, SHALL sustain 1 word/cycle; first word m_valid_o no later than 3 cycles after entering READ.
REQ-028 m_dat_o, m_lab_o, m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-029 After the last address is issued -> DRAIN until the FIFO is empty and the last word is transferred, then NEXT.
REQ-030 NEXT: clear the LAB's mask bit; remaining bits -> WAIT on next-lowest LAB; none -> REL.
REQ-031 REL: hold_o=0 for one cycle, then IDLE; busy_o falls on entering IDLE.
REQ-032 Word index and timeout counters SHALL not wrap; each resets to 0 on every LAB change.

Reset
REQ-033 rst_i=1 at any edge SHALL force IDLE, flush FIFO and in-flight reads, and clear all mask, counter and err state.
REQ-034 Output values while in reset: hold_o, digitize_o=0; addr_o=0; m_valid_o, m_last_o, busy_o, err_o=0; m_dat_o, m_lab_o=0.
REQ-035 Reset mid-READ SHALL release hold_o on the next edge; no partial word is presented after reset.

Verification
REQ-036 Mask 4'b0101, done_i rises 10 cycles after DIGI, m_ready_i=1 -> hold_o=0101; 1536 words LAB0 then 1536 LAB2; m_last_o on each word 1535; addr_o[12:11]=0 then 2; err_o=0.
REQ-037 Mask 4'b0001, m_ready_i random 50% -> exactly 1536 transfers, data equal RAM model contents in order, FIFO never overflows.
REQ-038 Mask 4'b0011, done_i never high for LAB0, TIMEOUT=64 -> err_o=1 after 64 WAIT cycles; LAB0 emits no words; LAB1 emits 1536; REL reached.
REQ-039 Trigger pulsed again during READ -> ignored; exactly one digitize_o pulse per run.
REQ-040 rst_i asserted at word 700 of LAB1 -> next edge hold_o=0, m_valid_o=0, busy_o=0; a new trigger gives a clean full run.
REQ-041 trig_i with mask_i=0 -> stays IDLE, busy_o=0, no hold_o or digitize_o activity.
